// File: rtl/buf_arb_pkg.sv
// Shared types and defaults for the buffer-port arbiter.
package buf_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int TO_CNT_W   = 8;

endpackage

// File: rtl/buf_arbiter_rr_pick2.sv
// Combinational two-way round-robin select: on a tie, the requester that
// was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;
    assign grant_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/buf_arbiter.sv
// Round-robin arbiter sharing the buffer port between the Wishbone front end (M0)
// and the SPI engine (M1). Optional ISSUE timeout with ERR pulses: BUF_ARB_TIMEOUT_EN.
module buf_arbiter
    import buf_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef BUF_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              WB_CLK_I,
    input  logic              WB_RST_N_I,
    input  logic              M0_REQ_I,
    input  logic              M0_WE_I,
    input  logic [ADDR_W-1:0] M0_ADR_I,
    input  logic [DATA_W-1:0] M0_DAT_I,
    output logic [DATA_W-1:0] M0_DAT_O,
    output logic              M0_ACK_O,
    input  logic              M1_REQ_I,
    input  logic              M1_WE_I,
    input  logic [ADDR_W-1:0] M1_ADR_I,
    input  logic [DATA_W-1:0] M1_DAT_I,
    output logic [DATA_W-1:0] M1_DAT_O,
    output logic              M1_ACK_O,
`ifdef BUF_ARB_TIMEOUT_EN
    output logic              M0_ERR_O,
    output logic              M1_ERR_O,
`endif
    output logic              BUF_STB_O,
    output logic              BUF_WR,
    output logic [ADDR_W-1:0] BUF_ADDR_O,
    output logic [DATA_W-1:0] BUF_DATA_O,
    input  logic [DATA_W-1:0] BUF_DATA_I,
    input  logic              BUF_ACK
);

    arb_state_t        state;
    logic              last_ptr;
    logic              gnt_idx;
    logic [1:0]        pick_req;
    logic              pick_valid;
    logic              pick_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_dat;

`ifdef BUF_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT - 1);
    logic [TO_CNT_W-1:0] to_cnt;
`endif

    // In DONE the requester just served is masked so it has a cycle to drop REQ.
    always_comb begin
        pick_req = 2'b00;
        if (state == ST_IDLE)
            pick_req = {M1_REQ_I, M0_REQ_I};
        else if (state == ST_DONE)
            pick_req = gnt_idx ? {1'b0, M0_REQ_I} : {M1_REQ_I, 1'b0};
    end

    rr_pick2 u_pick (
        .req         (pick_req),
        .last        (last_ptr),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign sel_we  = pick_idx ? M1_WE_I  : M0_WE_I;
    assign sel_adr = pick_idx ? M1_ADR_I : M0_ADR_I;
    assign sel_dat = pick_idx ? M1_DAT_I : M0_DAT_I;

    always_ff @(posedge WB_CLK_I or negedge WB_RST_N_I) begin
        if (!WB_RST_N_I) begin
            state      <= ST_IDLE;
            last_ptr   <= 1'b1;
            gnt_idx    <= 1'b0;
            BUF_STB_O  <= 1'b0;
            BUF_WR     <= 1'b0;
            BUF_ADDR_O <= '0;
            BUF_DATA_O <= '0;
            M0_DAT_O   <= '0;
            M1_DAT_O   <= '0;
            M0_ACK_O   <= 1'b0;
            M1_ACK_O   <= 1'b0;
`ifdef BUF_ARB_TIMEOUT_EN
            M0_ERR_O   <= 1'b0;
            M1_ERR_O   <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            M0_ACK_O <= 1'b0;
            M1_ACK_O <= 1'b0;
`ifdef BUF_ARB_TIMEOUT_EN
            M0_ERR_O <= 1'b0;
            M1_ERR_O <= 1'b0;
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (pick_valid) begin
                        gnt_idx    <= pick_idx;
                        last_ptr   <= pick_idx;
                        BUF_STB_O  <= 1'b1;
                        BUF_WR     <= sel_we;
                        BUF_ADDR_O <= sel_adr;
                        BUF_DATA_O <= sel_dat;
`ifdef BUF_ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        state      <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (BUF_ACK) begin
                        if (gnt_idx) begin
                            M1_ACK_O <= 1'b1;
                            if (!BUF_WR) M1_DAT_O <= BUF_DATA_I;
                        end else begin
                            M0_ACK_O <= 1'b1;
                            if (!BUF_WR) M0_DAT_O <= BUF_DATA_I;
                        end
                        BUF_STB_O <= 1'b0;
                        BUF_WR    <= 1'b0;
                        state     <= ST_RESP;
                    end
`ifdef BUF_ARB_TIMEOUT_EN
                    // A BUF_ACK arriving on the limit cycle takes the branch above.
                    else if (to_cnt == TO_LIMIT) begin
                        if (gnt_idx) M1_ERR_O <= 1'b1;
                        else         M0_ERR_O <= 1'b1;
                        BUF_STB_O <= 1'b0;
                        BUF_WR    <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_arbiter.sv
// Bench for buf_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard queue checked on the buffer side and on each response.
module tb_buf_arbiter;

    typedef struct {
        logic        idx;
        logic        we;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        err;
    } sb_t;

    typedef struct {
        logic        idx;
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        int          ack_lat;
        int          exp_lat;
        int          exp_stb;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [7:0]  m0_adr = 0, m1_adr = 0;
    logic [31:0] m0_dat = 0, m1_dat = 0;
    logic [31:0] M0_DAT_O, M1_DAT_O;
    logic        M0_ACK_O, M1_ACK_O;
    logic        m0_err, m1_err;
    logic        BUF_STB_O, BUF_WR;
    logic [7:0]  BUF_ADDR_O;
    logic [31:0] BUF_DATA_O;
    logic [31:0] BUF_DATA_I = 0;
    logic        BUF_ACK = 0;

    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    int   ack_lat = 1;
    int   scnt = 0;
    logic stray_ack = 0;
    sb_t  q[$];
    logic [31:0] last_rd [2];
    sb_t  mon_e;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    buf_arbiter #(
        .ADDR_W(8),
`ifdef BUF_ARB_TIMEOUT_EN
        .TIMEOUT(4),
`endif
        .DATA_W(32)
    ) dut (
        .WB_CLK_I   (clk),
        .WB_RST_N_I (rst_n),
        .M0_REQ_I   (m0_req),
        .M0_WE_I    (m0_we),
        .M0_ADR_I   (m0_adr),
        .M0_DAT_I   (m0_dat),
        .M0_DAT_O   (M0_DAT_O),
        .M0_ACK_O   (M0_ACK_O),
        .M1_REQ_I   (m1_req),
        .M1_WE_I    (m1_we),
        .M1_ADR_I   (m1_adr),
        .M1_DAT_I   (m1_dat),
        .M1_DAT_O   (M1_DAT_O),
        .M1_ACK_O   (M1_ACK_O),
`ifdef BUF_ARB_TIMEOUT_EN
        .M0_ERR_O   (m0_err),
        .M1_ERR_O   (m1_err),
`endif
        .BUF_STB_O  (BUF_STB_O),
        .BUF_WR     (BUF_WR),
        .BUF_ADDR_O (BUF_ADDR_O),
        .BUF_DATA_O (BUF_DATA_O),
        .BUF_DATA_I (BUF_DATA_I),
        .BUF_ACK    (BUF_ACK)
    );

`ifndef BUF_ARB_TIMEOUT_EN
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    function automatic logic [31:0] rd_fn(input logic [7:0] a);
        return (a == 8'h05) ? 32'hCAFEF00D : {4{a ^ 8'h3C}};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic idx, input logic req, input logic we,
                         input logic [7:0] adr, input logic [31:0] dat);
        if (idx) begin
            m1_req = req; m1_we = we; m1_adr = adr; m1_dat = dat;
        end else begin
            m0_req = req; m0_we = we; m0_adr = adr; m0_dat = dat;
        end
    endtask

    // Buffer model: ack on the ack_lat-th strobe cycle (0 = never).
    always @(posedge clk) begin
        #1;
        if (BUF_STB_O) begin
            scnt++;
            BUF_ACK = (ack_lat != 0) && (scnt == ack_lat);
        end else begin
            scnt = 0;
            BUF_ACK = stray_ack;
        end
        BUF_DATA_I = rd_fn(BUF_ADDR_O);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!BUF_STB_O) chk("wr_qual", 32'(BUF_WR), 0);
            if (BUF_STB_O && BUF_ACK) begin
                if (q.size() == 0) chk("buf_unexpected", 1, 0);
                else begin
                    chk("buf_wr", 32'(BUF_WR), 32'(q[0].we));
                    chk("buf_adr", 32'(BUF_ADDR_O), 32'(q[0].adr));
                    if (q[0].we) chk("buf_dat", BUF_DATA_O, q[0].wdat);
                end
            end
            if (M0_ACK_O || M1_ACK_O || m0_err || m1_err) begin
                if (q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("resp_src", 32'({M1_ACK_O | m1_err, M0_ACK_O | m0_err}), mon_e.idx ? 2 : 1);
                    chk("resp_err", 32'(m0_err | m1_err), 32'(mon_e.err));
                    mon_exp = (mon_e.we || mon_e.err) ? last_rd[mon_e.idx] : mon_e.rdat;
                    chk("dat_o", mon_e.idx ? M1_DAT_O : M0_DAT_O, mon_exp);
                    last_rd[mon_e.idx] = mon_exp;
                    n_done++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int cyc;
        int stb;
        bit got;
        q.push_back('{v.idx, v.we, v.adr, v.dat, rd_fn(v.adr), v.err});
        ack_lat = v.ack_lat;
        drive(v.idx, 1'b1, v.we, v.adr, v.dat);
        cyc = 0; stb = 0; got = 0;
        while (!got && cyc < 50) begin
            step();
            cyc++;
            if (BUF_STB_O) stb++;
            // Request fields change after grant and must not reach the buffer.
            if (cyc == 1) drive(v.idx, 1'b1, ~v.we, ~v.adr, ~v.dat);
            if (v.idx ? (M1_ACK_O | m1_err) : (M0_ACK_O | m0_err)) got = 1;
        end
        chk("latency", 32'(cyc), 32'(v.exp_lat));
        chk("stb_cycles", 32'(stb), 32'(v.exp_stb));
        drive(v.idx, 1'b0, 1'b0, 8'h00, 32'h0);
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt [6];
        sb_t  c0 [4];
        sb_t  c1 [4];
        int   cyc, stb, n0, n1, t, last_t, n_before;

        vt[0] = '{1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3, 4, 3, 1'b0};
        vt[1] = '{1'b1, 1'b0, 8'h05, 32'h00000000, 1, 2, 1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 8'h05, 32'h11111111, 2, 3, 2, 1'b0};
        vt[3] = '{1'b1, 1'b1, 8'hFF, 32'h12345678, 1, 2, 1, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 1, 2, 1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h80, 32'hFFFFFFFF, 4, 5, 4, 1'b0};
        for (int i = 0; i < 4; i++) begin
            c0[i] = '{1'b0, ~i[0], 8'h20 + 8'(i), 32'h10000000 + 32'(i), rd_fn(8'h20 + 8'(i)), 1'b0};
            c1[i] = '{1'b1, i[0], (i == 0) ? 8'h05 : 8'h40 + 8'(i), 32'h20000000 + 32'(i),
                      rd_fn((i == 0) ? 8'h05 : 8'h40 + 8'(i)), 1'b0};
        end
        last_rd[0] = 0;
        last_rd[1] = 0;

        step();
        step();
        chk("rst_stb", 32'(BUF_STB_O), 0);
        chk("rst_wr", 32'(BUF_WR), 0);
        chk("rst_adr", 32'(BUF_ADDR_O), 0);
        chk("rst_ack", 32'({M1_ACK_O, M0_ACK_O}), 0);
        rst_n = 1'b1;
        step();

        stray_ack = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        stray_ack = 1'b0;

        // M1 pulses REQ during M0's transfer; M0 holds REQ one cycle past ACK.
        n_before = n_done;
        q.push_back('{1'b0, 1'b1, 8'h33, 32'h0BADF00D, rd_fn(8'h33), 1'b0});
        ack_lat = 3;
        drive(1'b0, 1'b1, 1'b1, 8'h33, 32'h0BADF00D);
        step();
        drive(1'b1, 1'b1, 1'b0, 8'h66, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        cyc = 0;
        while (!M0_ACK_O && cyc < 20) begin step(); cyc++; end
        chk("withdraw_ack", 32'(M0_ACK_O), 1);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        stb = 0;
        repeat (5) begin step(); if (BUF_STB_O) stb++; end
        chk("holdoff_stb", 32'(stb), 0);
        chk("withdraw_cnt", 32'(n_done - n_before), 1);

        // Asynchronous reset in the middle of an ISSUE that never completes.
        ack_lat = 0;
        drive(1'b0, 1'b1, 1'b0, 8'h44, 32'h77);
        step();
        step();
        chk("mid_stb", 32'(BUF_STB_O), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stb", 32'(BUF_STB_O), 0);
        chk("arst_wr", 32'(BUF_WR), 0);
        chk("arst_adr", 32'(BUF_ADDR_O), 0);
        chk("arst_data", BUF_DATA_O, 0);
        chk("arst_ack", 32'({M1_ACK_O, M0_ACK_O}), 0);
        chk("arst_dat0", M0_DAT_O, 0);
        chk("arst_dat1", M1_DAT_O, 0);
        q.delete();
        last_rd[0] = 0;
        last_rd[1] = 0;

        // Contention from reset: M0 wins the tie, then strict alternation.
        ack_lat = 1;
        drive(1'b0, 1'b1, c0[0].we, c0[0].adr, c0[0].wdat);
        drive(1'b1, 1'b1, c1[0].we, c1[0].adr, c1[0].wdat);
        for (int i = 0; i < 4; i++) begin
            q.push_back(c0[i]);
            q.push_back(c1[i]);
        end
        step();
        rst_n = 1'b1;
        n0 = 0; n1 = 0; t = 0; last_t = -1;
        while ((n0 < 4 || n1 < 4) && t < 100) begin
            step();
            t++;
            if (M0_ACK_O || M1_ACK_O) begin
                if (last_t >= 0) chk("period", 32'(t - last_t), 3);
                last_t = t;
            end
            if (M0_ACK_O) begin
                n0++;
                if (n0 < 4) drive(1'b0, 1'b1, c0[n0].we, c0[n0].adr, c0[n0].wdat);
                else        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            end
            if (M1_ACK_O) begin
                n1++;
                if (n1 < 4) drive(1'b1, 1'b1, c1[n1].we, c1[n1].adr, c1[n1].wdat);
                else        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
            end
        end
        chk("cont_n0", 32'(n0), 4);
        chk("cont_n1", 32'(n1), 4);
        repeat (3) step();
        chk("cont_q_empty", 32'(q.size()), 0);

`ifdef BUF_ARB_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b0, 1'b0, 8'h50, 32'h0, 0, 5, 4, 1'b1};
            run_vec(tv);
            tv = '{1'b0, 1'b0, 8'h51, 32'h0, 4, 5, 4, 1'b0};
            run_vec(tv);
        end
`endif

        repeat (2) step();
        chk("final_q_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
